// File: rtl/match_score_accumulator.sv
// Two-stage hit grader and score/combo/multiplier accumulator for the note-match stream.
// Optional SCORE_EARLY_LATE_EN adds early_cnt/late_cnt counters for non-PERFECT hits.
module match_score_accumulator #(
  parameter int PERFECT_WIN    = 20,
  parameter int GOOD_WIN       = 50,
  parameter int OK_WIN         = 100,
  parameter int SCORE_W        = 24,
  parameter int COMBO_W        = 10,
  parameter int COMBO_PER_MULT = 10,
  parameter int MULT_MAX       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               match_en,
  input  logic [15:0]        match_dt,
  input  logic               miss_en,
  output logic               hit_valid,
  output logic [1:0]         hit_grade,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         multiplier,
  output logic [COMBO_W-1:0] max_combo
`ifdef SCORE_EARLY_LATE_EN
  ,
  output logic [15:0]        early_cnt,
  output logic [15:0]        late_cnt
`endif
);

  // match_en/miss_en are valid-only strobes: no ready, every cycle's event is
  // accepted; hit_valid is a one-cycle result strobe with no backpressure.

  localparam int SUB_W = $clog2(COMBO_PER_MULT + 1);
  localparam int ADD_W = ((SCORE_W > 10) ? SCORE_W : 10) + 1;

  localparam logic [15:0]      PERFECT_LIM = 16'(PERFECT_WIN);
  localparam logic [15:0]      GOOD_LIM    = 16'(GOOD_WIN);
  localparam logic [15:0]      OK_LIM      = 16'(OK_WIN);
  localparam logic [SUB_W-1:0] SUB_WRAP    = SUB_W'(COMBO_PER_MULT);
  localparam logic [2:0]       MULT_LIM    = 3'(MULT_MAX);
  localparam logic [ADD_W-1:0] SCORE_MAX   = ADD_W'({SCORE_W{1'b1}});

  // ---------------- stage 1: capture event and |dt| ----------------
  logic        s1_en;
  logic        s1_miss;
  logic        s1_neg;
  logic        s1_pos;
  logic [15:0] s1_abs;
  logic [15:0] dt_abs;

  always_comb begin
    dt_abs = match_dt;
    if (match_dt[15]) begin
      // -32768 has no positive counterpart in 16 bits
      dt_abs = (match_dt == 16'h8000) ? 16'h7FFF : (~match_dt + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_en   <= 1'b0;
      s1_miss <= 1'b0;
      s1_neg  <= 1'b0;
      s1_pos  <= 1'b0;
      s1_abs  <= 16'd0;
    end else if (clear) begin
      s1_en   <= 1'b0;
      s1_miss <= 1'b0;
      s1_neg  <= 1'b0;
      s1_pos  <= 1'b0;
      s1_abs  <= 16'd0;
    end else begin
      s1_en   <= match_en;
      s1_miss <= miss_en;
      s1_neg  <= match_dt[15];
      s1_pos  <= ~match_dt[15] & (match_dt != 16'd0);
      s1_abs  <= dt_abs;
    end
  end

  // ---------------- stage 2: grade and accumulate ----------------
  logic [1:0]         grade;
  logic               is_hit;
  logic [6:0]         pts;
  logic [9:0]         add_val;
  logic [ADD_W-1:0]   sum;
  logic [COMBO_W-1:0] combo_hit;
  logic [SUB_W-1:0]   sub_cnt;
  logic [SUB_W-1:0]   sub_inc;

  logic [SCORE_W-1:0] score_nxt;
  logic [COMBO_W-1:0] combo_nxt;
  logic [COMBO_W-1:0] max_nxt;
  logic [2:0]         mult_nxt;
  logic [SUB_W-1:0]   sub_nxt;
  logic               valid_nxt;
  logic [1:0]         grade_nxt;

  always_comb begin
    grade = 2'd0;
    if (s1_abs <= PERFECT_LIM)   grade = 2'd3;
    else if (s1_abs <= GOOD_LIM) grade = 2'd2;
    else if (s1_abs <= OK_LIM)   grade = 2'd1;

    is_hit = s1_en && (grade != 2'd0);

    pts = 7'd0;
    case (grade)
      2'd3:    pts = 7'd100;
      2'd2:    pts = 7'd50;
      2'd1:    pts = 7'd20;
      default: pts = 7'd0;
    endcase

    // points use the multiplier held before this event
    add_val = {3'b000, pts} * {7'b0000000, multiplier};
    sum     = ADD_W'(score) + ADD_W'(add_val);

    combo_hit = (combo == {COMBO_W{1'b1}}) ? combo : combo + COMBO_W'(1);
    sub_inc   = sub_cnt + SUB_W'(1);

    score_nxt = score;
    combo_nxt = combo;
    max_nxt   = max_combo;
    mult_nxt  = multiplier;
    sub_nxt   = sub_cnt;
    valid_nxt = s1_en | s1_miss;
    grade_nxt = hit_grade;

    if (is_hit) begin
      score_nxt = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
      combo_nxt = combo_hit;
      if (combo_hit > max_combo) max_nxt = combo_hit;
      if (sub_inc == SUB_WRAP) begin
        sub_nxt = '0;
        if (multiplier < MULT_LIM) mult_nxt = multiplier + 3'd1;
      end else begin
        sub_nxt = sub_inc;
      end
    end

    // a miss (or graded miss) overrides the streak after any hit was scored
    if (s1_miss || (s1_en && grade == 2'd0)) begin
      combo_nxt = '0;
      mult_nxt  = 3'd1;
      sub_nxt   = '0;
    end

    if (s1_en)        grade_nxt = grade;
    else if (s1_miss) grade_nxt = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid  <= 1'b0;
      hit_grade  <= 2'd0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      multiplier <= 3'd1;
      sub_cnt    <= '0;
    end else if (clear) begin
      hit_valid  <= 1'b0;
      hit_grade  <= 2'd0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      multiplier <= 3'd1;
      sub_cnt    <= '0;
    end else begin
      hit_valid  <= valid_nxt;
      hit_grade  <= grade_nxt;
      score      <= score_nxt;
      combo      <= combo_nxt;
      max_combo  <= max_nxt;
      multiplier <= mult_nxt;
      sub_cnt    <= sub_nxt;
    end
  end

`ifdef SCORE_EARLY_LATE_EN
  logic count_el;
  assign count_el = s1_en && (grade == 2'd1 || grade == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_cnt <= 16'd0;
      late_cnt  <= 16'd0;
    end else if (clear) begin
      early_cnt <= 16'd0;
      late_cnt  <= 16'd0;
    end else if (count_el) begin
      if (s1_neg && early_cnt != 16'hFFFF) early_cnt <= early_cnt + 16'd1;
      if (s1_pos && late_cnt != 16'hFFFF)  late_cnt  <= late_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_match_score_accumulator.sv
// Directed bench for match_score_accumulator: default instance plus an SCORE_W=8 instance
// for score saturation; early/late counters checked when SCORE_EARLY_LATE_EN is defined.
module tb_match_score_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic match_en;
  logic miss_en;
  logic [15:0] match_dt;

  always #5 clk = ~clk;

  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic [23:0] score;
  logic [9:0]  combo;
  logic [2:0]  multiplier;
  logic [9:0]  max_combo;

  logic        s_hit_valid;
  logic [1:0]  s_hit_grade;
  logic [7:0]  s_score;
  logic [9:0]  s_combo;
  logic [2:0]  s_multiplier;
  logic [9:0]  s_max_combo;

`ifdef SCORE_EARLY_LATE_EN
  logic [15:0] early_cnt, late_cnt, s_early_cnt, s_late_cnt;
`endif

  match_score_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .match_en(match_en), .match_dt(match_dt), .miss_en(miss_en),
    .hit_valid(hit_valid), .hit_grade(hit_grade), .score(score),
    .combo(combo), .multiplier(multiplier), .max_combo(max_combo)
`ifdef SCORE_EARLY_LATE_EN
    , .early_cnt(early_cnt), .late_cnt(late_cnt)
`endif
  );

  match_score_accumulator #(.SCORE_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .match_en(match_en), .match_dt(match_dt), .miss_en(miss_en),
    .hit_valid(s_hit_valid), .hit_grade(s_hit_grade), .score(s_score),
    .combo(s_combo), .multiplier(s_multiplier), .max_combo(s_max_combo)
`ifdef SCORE_EARLY_LATE_EN
    , .early_cnt(s_early_cnt), .late_cnt(s_late_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_main(input string tag, input logic hv, input logic [1:0] g,
                            input int sc, input int cb, input int ml, input int mx);
    check({tag, ".hit_valid"},  32'(hit_valid),  32'(hv));
    check({tag, ".hit_grade"},  32'(hit_grade),  32'(g));
    check({tag, ".score"},      32'(score),      32'(sc));
    check({tag, ".combo"},      32'(combo),      32'(cb));
    check({tag, ".multiplier"}, 32'(multiplier), 32'(ml));
    check({tag, ".max_combo"},  32'(max_combo),  32'(mx));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    match_en = 1'b0;
    miss_en  = 1'b0;
    match_dt = 16'd0;
  endtask

  task automatic drive(input logic en, input logic [15:0] dt, input logic ms);
    @(negedge clk);
    match_en = en;
    match_dt = dt;
    miss_en  = ms;
  endtask

  // drive one event, then stop at the negedge where its result is visible
  task automatic one_event(input logic en, input logic [15:0] dt, input logic ms);
    drive(en, dt, ms);
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic flush();
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_main("reset", 1'b0, 2'd0, 0, 0, 1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    one_event(1'b1, 16'h0005, 1'b0);
    check_main("perfect5", 1'b1, 2'd3, 100, 1, 1, 1);
    one_event(1'b1, 16'hFFD8, 1'b0);
    check_main("good_m40", 1'b1, 2'd2, 150, 2, 1, 2);
    one_event(1'b1, 16'h0064, 1'b0);
    check_main("ok_100", 1'b1, 2'd1, 170, 3, 1, 3);
    one_event(1'b1, 16'h0096, 1'b0);
    check_main("miss_150", 1'b1, 2'd0, 170, 0, 1, 3);
    one_event(1'b1, 16'h8000, 1'b0);
    check_main("miss_8000", 1'b1, 2'd0, 170, 0, 1, 3);

    one_event(1'b1, 16'd20, 1'b0);
    check_main("perfect_20", 1'b1, 2'd3, 270, 1, 1, 3);
    @(negedge clk);
    check("idle.hit_valid", 32'(hit_valid), 32'd0);
    check("idle.grade_hold", 32'(hit_grade), 32'd3);
    one_event(1'b1, 16'd21, 1'b0);
    check_main("good_21", 1'b1, 2'd2, 320, 2, 1, 3);
    one_event(1'b1, 16'hFFCE, 1'b0);
    check_main("good_m50", 1'b1, 2'd2, 370, 3, 1, 3);
    one_event(1'b1, 16'hFFCD, 1'b0);
    check_main("ok_m51", 1'b1, 2'd1, 390, 4, 1, 4);
    one_event(1'b1, 16'd101, 1'b0);
    check_main("miss_101", 1'b1, 2'd0, 390, 0, 1, 4);
    one_event(1'b1, 16'd0, 1'b0);
    one_event(1'b0, 16'd0, 1'b1);
    check_main("miss_strobe", 1'b1, 2'd0, 490, 0, 1, 4);

    // multiplier stepping, back-to-back events
    do_clear();
    check_main("clear", 1'b0, 2'd0, 0, 0, 1, 0);
    for (int i = 0; i < 11; i++) drive(1'b1, 16'd0, 1'b0);
    flush();
    check_main("mult11", 1'b1, 2'd3, 1200, 11, 2, 11);
    for (int i = 0; i < 34; i++) drive(1'b1, 16'd0, 1'b0);
    flush();
    check_main("mult_cap45", 1'b1, 2'd3, 12000, 45, 4, 45);

    // simultaneous hit and miss
    do_clear();
    for (int i = 0; i < 5; i++) drive(1'b1, 16'd0, 1'b0);
    flush();
    check("pre_sim.combo", 32'(combo), 32'd5);
    one_event(1'b1, 16'd0, 1'b1);
    check_main("sim_hit_miss", 1'b1, 2'd3, 600, 0, 1, 6);

`ifdef SCORE_EARLY_LATE_EN
    do_clear();
    one_event(1'b1, 16'hFFE2, 1'b0);
    check("el_m30.early", 32'(early_cnt), 32'd1);
    check("el_m30.late",  32'(late_cnt),  32'd0);
    one_event(1'b1, 16'd60, 1'b0);
    check("el_60.early", 32'(early_cnt), 32'd1);
    check("el_60.late",  32'(late_cnt),  32'd1);
    one_event(1'b1, 16'hFFFB, 1'b0);
    check("el_m5.early", 32'(early_cnt), 32'd1);
    check("el_m5.late",  32'(late_cnt),  32'd1);
`endif

    // clear with an event in flight drops it
    do_clear();
    drive(1'b1, 16'd0, 1'b0);
    @(negedge clk);
    idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("inflight.hit_valid", 32'(hit_valid), 32'd0);
    check("inflight.score", 32'(score), 32'd0);
    @(negedge clk);
    check("inflight.hit_valid2", 32'(hit_valid), 32'd0);
    check("inflight.combo", 32'(combo), 32'd0);

    // score saturation on the 8-bit instance
    do_clear();
    one_event(1'b1, 16'd0, 1'b0);
    check("sat1.score", 32'(s_score), 32'd100);
    one_event(1'b1, 16'd0, 1'b0);
    check("sat2.score", 32'(s_score), 32'd200);
    one_event(1'b1, 16'd0, 1'b0);
    check("sat3.score", 32'(s_score), 32'd255);
    one_event(1'b1, 16'd0, 1'b0);
    check("sat4.score", 32'(s_score), 32'd255);
    check("sat4.combo", 32'(s_combo), 32'd4);

    // asynchronous reset mid-stream, checked before any further clock edge
    drive(1'b1, 16'd0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async_rst", 1'b0, 2'd0, 0, 0, 1, 0);
    check("async_rst.s_score", 32'(s_score), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/match_score_accumulator.md
Name: match_score_accumulator

Overview:
- Receiving end of the serialized match stream produced by the note-matching buffer serializer.
- Consumes one (match_en, match_dt) pair per clock.
- Grades each hit by timing error, then maintains score, combo, multiplier and max-combo for the display/HUD logic.
- Also takes a miss strobe from the note-expiry logic.

Parameters:
- PERFECT_WIN, 20: max |dt| (song_time ticks) for grade PERFECT, inclusive.
- GOOD_WIN, 50: max |dt| for grade GOOD, inclusive.
- OK_WIN, 100: max |dt| for grade OK, inclusive; beyond this is a miss.
- SCORE_W, 24: score width.
- COMBO_W, 10: combo and max_combo width.
- COMBO_PER_MULT, 10: consecutive hits per multiplier step.
- MULT_MAX, 4: multiplier ceiling, range 1..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous song restart; clears all state.
- match_en  in  1  valid match this cycle.
- match_dt  in  16  signed two's-complement timing error, song_time minus note time.
- miss_en  in  1  note expired unplayed.
- hit_valid  out  1  one-cycle strobe, grade result available.
- hit_grade  out  2  3=PERFECT, 2=GOOD, 1=OK, 0=MISS.
- score  out  SCORE_W  accumulated score.
- combo  out  COMBO_W  current streak.
- multiplier  out  3  current multiplier, 1..MULT_MAX.
- max_combo  out  COMBO_W  best streak since reset/clear.

Behaviour:
- Reset (async, rst_n=0) and clear (sync, highest priority) give:
  - score=0, combo=0, max_combo=0, multiplier=1.
  - hit_valid=0, hit_grade=0.
  - sub-counter=0, pipeline valid bits=0.
- Pipeline stage 1 registers en, miss and |dt|.
  - |dt| is computed signed.
  - dt=0x8000 saturates to 0x7FFF.
- Stage 2 grades, updates state and drives outputs.
- Latency: match_en or miss_en at cycle N gives hit_valid/state update at N+2. Fully pipelined, one event per cycle.
- Grading uses inclusive bounds:
  - |dt|<=PERFECT_WIN → 3.
  - else |dt|<=GOOD_WIN → 2.
  - else |dt|<=OK_WIN → 1.
  - else 0.
- Points: PERFECT 100, GOOD 50, OK 20. Each is multiplied by the multiplier value held before this event.
- Score add saturates at 2^SCORE_W-1 and never wraps.
- Hit (grade>=1):
  - combo+1, saturating at 2^COMBO_W-1.
  - Sub-counter+1; on reaching COMBO_PER_MULT it returns to 0 and multiplier+1, capped at MULT_MAX.
  - At the cap the sub-counter keeps wrapping with no effect.
- Grade 0 from match_en, or any miss_en: combo=0, multiplier=1, sub-counter=0, no points.
- max_combo is updated to max(max_combo, new combo) in the same cycle.
- Simultaneous match_en and miss_en:
  - Hit is graded and scored first.
  - Then the miss reset applies: combo 0, multiplier 1.
  - max_combo still sees the post-hit combo.
  - hit_valid=1 with the hit's grade.
- miss_en alone: hit_valid=1, hit_grade=0.
- No event: hit_valid=0; hit_grade holds its last value.
- clear during in-flight events discards them; no hit_valid is produced for them.

Optional Feature:
- Macro: SCORE_EARLY_LATE_EN.
- Defined: adds output ports early_cnt[15:0] and late_cnt[15:0].
  - Counted only for non-PERFECT hits (grade 1 or 2).
  - match_dt<0 increments early_cnt; match_dt>0 increments late_cnt.
  - Both saturate at 0xFFFF.
  - Both are cleared by reset/clear and sampled with the same 2-cycle latency.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst_n low mid-stream → all outputs 0 except multiplier=1, immediately and asynchronously.
- Perfect hit: match_en with dt=0x0005 → 2 cycles later hit_valid=1, grade 3, score=100, combo=1.
- Grade boundaries: dt=0xFFD8 (-40) → grade 2, +50; dt=0x0064 (100) → grade 1, +20; dt=0x0096 (150) → grade 0, combo 0, score unchanged; dt=0x8000 → grade 0.
- Multiplier step: 11 consecutive dt=0 hits → multiplier 2 after the 10th; 11th adds 200; score=1200, combo=11, max_combo=11.
- Score saturation: SCORE_W=8, three dt=0 hits → score 100, 200, 255; a fourth hit stays at 255.
- Simultaneous events: match_en dt=0 with miss_en, starting from combo=5 → +100, grade 3, combo=0, multiplier=1, max_combo>=6. With SCORE_EARLY_LATE_EN, dt=-30 → early_cnt=1, late_cnt=0.
